// File: rtl/alu181_serial.sv
// Nibble-serial 74181-compatible ALU: one 4-bit slice per clock, LSB first, registered inter-slice carry.
// Result and flags appear N=WIDTH/4 cycles after acceptance; held frozen while out_ready is low.
module alu181_serial #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             ci,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             ovf,
   output logic             zero,
   output logic             aeqb
);

   localparam int N    = WIDTH / 4;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       s_q, s_d;
   logic             m_q, m_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             aeqb_q, aeqb_d;

   logic [IDXW+1:0]  base;
   logic [3:0]       a_sl, b_sl, x_sl, y_sl, f_sl;
   logic [4:0]       cc;

   // Slice datapath: 74181 X/Y generate terms, then ripple across the nibble.
   always_comb begin
      base  = {idx_q, 2'b00};
      a_sl  = a_q[base +: 4];
      b_sl  = b_q[base +: 4];
      x_sl  = a_sl | (b_sl & {4{s_q[0]}}) | (~b_sl & {4{s_q[1]}});
      y_sl  = (a_sl & ~b_sl & {4{s_q[2]}}) | (a_sl & b_sl & {4{s_q[3]}});
      cc    = '0;
      cc[0] = carry_q;
      f_sl  = '0;
      for (int i = 0; i < 4; i++) begin
         f_sl[i]  = m_q ? ~(x_sl[i] ^ y_sl[i]) : (x_sl[i] ^ y_sl[i] ^ cc[i]);
         cc[i+1]  = (x_sl[i] & y_sl[i]) | (cc[i] & (x_sl[i] ^ y_sl[i]));
      end
   end

   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      m_d      = m_q;
      a_d      = a_q;
      b_d      = b_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      work_d   = work_q;
      y_d      = y_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      aeqb_d   = aeqb_q;
      in_ready = 1'b0;

      case (state_q)
         IDLE: in_ready = 1'b1;
         RUN: begin
            work_d[base +: 4] = f_sl;
            carry_d           = cc[4];
            idx_d             = idx_q + IDXW'(1);
            if (idx_q == IDXW'(N - 1)) begin
               y_d     = work_d;
               cout_d  = ~m_q & cc[4];
               ovf_d   = ~m_q & (cc[3] ^ cc[4]);
               zero_d  = (work_d == '0);
               aeqb_d  = &work_d;
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            in_ready = out_ready;
            if (out_ready && !in_valid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Acceptance from IDLE or back-to-back from DONE as the result is taken.
      if (in_valid && in_ready) begin
         s_d     = s;
         m_d     = m;
         a_d     = a;
         b_d     = b;
         carry_d = ci;
         idx_d   = '0;
         state_d = RUN;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         m_q     <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         work_q  <= '0;
         y_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         aeqb_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         m_q     <= m_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         work_q  <= work_d;
         y_q     <= y_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         aeqb_q  <= aeqb_d;
      end
   end

   assign out_valid = (state_q == DONE);
   assign y         = y_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;
   assign aeqb      = aeqb_q;

endmodule

// File: tb/tb_alu181_serial.sv
// Directed bench for alu181_serial (WIDTH=16): vector table plus backpressure and mid-op reset sequences.
module tb_alu181_serial;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  s = '0;
   logic        m = 1'b0;
   logic        ci = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] y;
   logic        cout, ovf, zero, aeqb;

   int checks = 0;
   int failures = 0;

   alu181_serial #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .s(s), .m(m), .ci(ci), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .cout(cout), .ovf(ovf), .zero(zero), .aeqb(aeqb)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  s;
      logic        m;
      logic        ci;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] y;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        aeqb;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Presents an op, waits (bounded) for acceptance, then scrambles the inputs.
   task automatic issue(input logic [3:0] ts, input logic tm, input logic tci,
                        input logic [15:0] ta, input logic [15:0] tb_);
      int t;
      @(negedge clk);
      s = ts; m = tm; ci = tci; a = ta; b = tb_;
      in_valid = 1'b1;
      t = 0;
      #1;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("accept_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      s = ~ts; m = ~tm; ci = ~tci; a = 16'hDEAD; b = 16'hBEEF;
   endtask

   // Called 1 time unit after the accepting edge; counts edges until out_valid.
   task automatic wait_result(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("out_valid_drop", out_valid, 0);
   endtask

   initial begin
      int lat;
      logic [15:0] held;

      vecs[0]  = '{4'd9,  1'b0, 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{4'd6,  1'b0, 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{4'd6,  1'b0, 1'b1, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{4'd9,  1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{4'd9,  1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{4'd6,  1'b1, 1'b0, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{4'd9,  1'b1, 1'b0, 16'hABCD, 16'hABCD, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{4'd3,  1'b1, 1'b0, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{4'd3,  1'b1, 1'b1, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{4'd0,  1'b0, 1'b1, 16'hFFFF, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{4'd15, 1'b0, 1'b0, 16'h8000, 16'h5555, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};

      // Reset state
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_y", y, 0);
      check("rst_flags", {cout, ovf, zero, aeqb}, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("post_rst_in_ready", in_ready, 1);

      for (int i = 0; i < 11; i++) begin
         issue(vecs[i].s, vecs[i].m, vecs[i].ci, vecs[i].a, vecs[i].b);
         check($sformatf("v%0d_busy", i), in_ready, 0);
         wait_result(lat);
         check($sformatf("v%0d_latency", i), lat, 4);
         check($sformatf("v%0d_y", i), y, vecs[i].y);
         check($sformatf("v%0d_cout", i), cout, vecs[i].cout);
         check($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
         check($sformatf("v%0d_zero", i), zero, vecs[i].zero);
         check($sformatf("v%0d_aeqb", i), aeqb, vecs[i].aeqb);
         take();
      end

      // Backpressure: result frozen, new request ignored until out_ready.
      issue(4'd9, 1'b0, 1'b0, 16'h0100, 16'h0200);
      wait_result(lat);
      check("bp_latency", lat, 4);
      check("bp_y", y, 16'h0300);
      s = 4'd9; m = 1'b0; ci = 1'b0; a = 16'h0011; b = 16'h0022;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("bp_hold%0d_in_ready", k), in_ready, 0);
         @(posedge clk);
         #1;
         check($sformatf("bp_hold%0d_out_valid", k), out_valid, 1);
         check($sformatf("bp_hold%0d_y", k), y, 16'h0300);
         check($sformatf("bp_hold%0d_flags", k), {cout, ovf, zero, aeqb}, 0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = 16'hDEAD; b = 16'hBEEF;
      check("b2b_out_valid_drop", out_valid, 0);
      wait_result(lat);
      check("b2b_latency", lat, 4);
      check("b2b_y", y, 16'h0033);
      take();

      // Reset two cycles into RUN: nothing partial may surface.
      issue(4'd9, 1'b0, 1'b0, 16'h00F0, 16'h000F);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_y", y, 0);
      check("mid_rst_flags", {cout, ovf, zero, aeqb}, 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("mid_rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      check("mid_rst_no_result", out_valid, 0);
      issue(4'd9, 1'b0, 1'b0, 16'h0001, 16'h0001);
      wait_result(lat);
      check("fresh_latency", lat, 4);
      held = y;
      check("fresh_y", held, 16'h0002);
      take();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
